ex_result_stage: RTL and testbench

Execute-stage result register sitting directly downstream of the ALU in the Zero-RISC-V pipeline.
- Captures the ALU sum/logic result and the C/V/Z/N flags together with instruction metadata, resolves conditional branches from those flags, and presents the result to the memory stage.
- Provides a two-entry skid buffer with valid/ready handshaking so that `in_ready` is a registered signal.
- Issues a one-cycle front-end redirect when a branch outcome differs from its prediction.

---
 rtl/ex_result_stage.sv | 121 ++++++++++++
 tb/tb_ex_result_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// Execute-stage result register: resolves branches from ALU flags and hands
// results to the memory stage through a two-entry skid buffer.
module ex_result_stage #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] alu_result,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic [4:0]      rd_addr,
  input  logic            reg_we,
  input  logic            is_branch,
  input  logic [2:0]      br_funct3,
  input  logic [size-1:0] br_target,
  input  logic [size-1:0] pc_plus4,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            redirect_valid,
  output logic [size-1:0] redirect_pc
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [size-1:0] result;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          main_q, main_d, skid_q, skid_d, in_entry;
  logic            redirect_valid_q, redirect_valid_d;
  logic [size-1:0] redirect_pc_q, redirect_pc_d;
  logic            accept, pop, taken, mispredict;

  // alu_c is "no borrow" from A-B, i.e. A >= B unsigned
  always_comb begin
    taken = 1'b0;
    case (br_funct3)
      3'b000:  taken = alu_z;
      3'b001:  taken = !alu_z;
      3'b100:  taken = alu_n ^ alu_v;
      3'b101:  taken = !(alu_n ^ alu_v);
      3'b110:  taken = !alu_c;
      3'b111:  taken = alu_c;
      default: taken = 1'b0;
    endcase
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign mispredict = accept && is_branch && (taken != pred_taken);

  always_comb begin
    in_entry         = '{result: alu_result, rd: rd_addr, we: reg_we && !is_branch};
    state_d          = state_q;
    main_d           = main_q;
    skid_d           = skid_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (mispredict) redirect_pc_d = taken ? br_target : pc_plus4;

    case (state_q)
      EMPTY: if (accept) begin
        main_d  = in_entry;
        state_d = ONE;
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase

    // data registers are left as-is; only occupancy is discarded
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= EMPTY;
      main_q           <= '0;
      skid_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      main_q           <= main_d;
      skid_q           <= skid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_we         = main_q.we;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized bench for ex_result_stage: operands A/B are generated, flags are
// derived from A-B, and expectations come from direct A/B comparisons.
module tb_ex_result_stage;
  localparam int W = 32;

  logic         clk, rst_n, flush, in_valid, in_ready;
  logic [W-1:0] alu_result, br_target, pc_plus4, out_result, redirect_pc;
  logic         alu_c, alu_v, alu_z, alu_n, reg_we, is_branch, pred_taken;
  logic [4:0]   rd_addr, out_rd;
  logic [2:0]   br_funct3;
  logic         out_valid, out_ready, out_we, redirect_valid;
  logic [W-1:0] op_a, op_b;

  ex_result_stage #(.size(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .rd_addr(rd_addr), .reg_we(reg_we), .is_branch(is_branch), .br_funct3(br_funct3),
    .br_target(br_target), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] res; logic [4:0] rd; logic we;} beat_t;
  beat_t        sb[$];
  logic         rv_exp;
  logic [W-1:0] rpc_exp;
  int           n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // branch outcome straight from the operands
  function automatic bit ref_taken(logic [2:0] f3, logic [W-1:0] a, logic [W-1:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) <  $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 0;
    endcase
  endfunction

  // scoreboard / monitor: compare present outputs, then advance the model
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); rv_exp = 0; rpc_exp = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      bit pop, acc, tk;
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, sb.size() < 2);
      chk("redirect_valid", redirect_valid, rv_exp);
      if (rv_exp) chk("redirect_pc", redirect_pc, rpc_exp);
      if (sb.size() != 0) begin
        chk("out_result", out_result, sb[0].res);
        chk("out_rd", out_rd, sb[0].rd);
        chk("out_we", out_we, sb[0].we);
      end
      pop = (sb.size() != 0) && out_ready;
      acc = in_valid && (sb.size() < 2) && !flush;
      tk  = ref_taken(br_funct3, op_a, op_b);
      rv_exp = acc && is_branch && (tk != pred_taken);
      if (rv_exp) rpc_exp = tk ? br_target : pc_plus4;
      if (flush) sb.delete();
      else begin
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back('{res: alu_result, rd: rd_addr, we: reg_we && !is_branch});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_arith(logic [W-1:0] res, logic [4:0] rd, logic we);
    is_branch = 0; alu_result = res; rd_addr = rd; reg_we = we;
    op_a = $urandom; op_b = $urandom; br_funct3 = 3'($urandom);
    {alu_c, alu_v, alu_z, alu_n} = 4'($urandom);
    pred_taken = $urandom; br_target = $urandom; pc_plus4 = $urandom;
  endtask

  task automatic set_branch(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] f3, logic pred,
                            logic [W-1:0] tgt, logic [W-1:0] pc4);
    logic [W-1:0] d;
    d = a - b;
    op_a = a; op_b = b; is_branch = 1; br_funct3 = f3; pred_taken = pred;
    br_target = tgt; pc_plus4 = pc4; alu_result = d;
    rd_addr = 5'($urandom); reg_we = $urandom;
    alu_z = (d == 0); alu_n = d[W-1]; alu_c = (a >= b);
    alu_v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // hold in_valid until the stage takes the beat (bounded)
  task automatic send();
    int k = 0; bit acc = 0;
    in_valid = 1;
    while (!acc && k < 50) begin
      @(negedge clk); acc = in_ready && !flush;
      @(posedge clk); #1; k++;
    end
    in_valid = 0;
    if (!acc) begin n_chk++; n_fail++; $display("FAIL send_timeout: beat not accepted in 50 cycles"); end
  endtask

  logic [W-1:0] ba [3] = '{32'd7, 32'd1, 32'd5};
  logic [W-1:0] bb [3] = '{32'd7, 32'd2, 32'd3};
  logic [2:0]   bf [3] = '{3'b000, 3'b100, 3'b111};

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    set_arith(0, 0, 0);
    step(3);
    rst_n = 1;
    step(2);

    // arithmetic pass-through
    out_ready = 1;
    set_arith(32'hFF, 5'd5, 1);
    send();
    chk("pt_valid", out_valid, 1); chk("pt_result", out_result, 32'hFF);
    chk("pt_rd", out_rd, 5); chk("pt_we", out_we, 1); chk("pt_redirect", redirect_valid, 0);
    step(2);

    // branch decode sweep, mispredicted then correctly predicted
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) begin
        set_branch(ba[i], bb[i], bf[i], 1'(p), 32'h100, 32'h200);
        send();
        chk("sweep_redirect", redirect_valid, p == 0);
        if (p == 0) chk("sweep_pc", redirect_pc, 32'h100);
        chk("sweep_we", out_we, 0);
        step(1);
        chk("sweep_pulse_end", redirect_valid, 0);
      end

    // not-taken mispredict
    set_branch(32'd9, 32'd9, 3'b001, 1, 32'h100, 32'h84);
    send();
    chk("bne_redirect", redirect_valid, 1); chk("bne_pc", redirect_pc, 32'h84);
    step(1);
    chk("bne_pulse_end", redirect_valid, 0);
    step(1);

    // backpressure: A, B fill the buffer, C stalls
    out_ready = 0;
    set_arith(32'hA, 1, 1); send();
    set_arith(32'hB, 2, 1); send();
    chk("bp_in_ready_low", in_ready, 0);
    set_arith(32'hC, 3, 1); in_valid = 1;
    step(3);
    chk("bp_hold_A", out_result, 32'hA);
    out_ready = 1; send();
    step(4);

    // flush in FULL with a mispredicting branch on the input
    out_ready = 0;
    set_arith(32'h11, 4, 1); send();
    set_arith(32'h22, 6, 1); send();
    set_branch(32'd1, 32'd1, 3'b000, 0, 32'h300, 32'h304);
    in_valid = 1; flush = 1;
    step(1);
    flush = 0; in_valid = 0;
    chk("fl_out_valid", out_valid, 0); chk("fl_in_ready", in_ready, 1);
    chk("fl_redirect", redirect_valid, 0);
    // flush in ONE drops the incoming mispredict too
    set_arith(32'h33, 7, 1); send();
    set_branch(32'd1, 32'd2, 3'b100, 0, 32'h400, 32'h404);
    in_valid = 1; flush = 1;
    step(1);
    flush = 0; in_valid = 0;
    chk("fl1_out_valid", out_valid, 0); chk("fl1_redirect", redirect_valid, 0);
    step(1);

    // async reset while FULL with a redirect pulse showing
    set_arith(32'h44, 8, 1); send();
    set_branch(32'd3, 32'd4, 3'b110, 0, 32'h500, 32'h504); send();
    chk("ar_pre_redirect", redirect_valid, 1);
    chk("ar_pre_full", in_ready, 0);
    #1 rst_n = 0;
    #1;
    chk("ar_out_valid", out_valid, 0); chk("ar_out_result", out_result, 0);
    chk("ar_out_rd", out_rd, 0); chk("ar_out_we", out_we, 0);
    chk("ar_redirect_valid", redirect_valid, 0); chk("ar_redirect_pc", redirect_pc, 0);
    chk("ar_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    set_arith(32'h55, 9, 1); send();
    chk("ar_clean_result", out_result, 32'h55);
    step(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = $urandom;
      if ($urandom_range(0, 1)) begin
        logic [W-1:0] a, b;
        a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_branch(a, b, 3'($urandom), 1'($urandom), $urandom, $urandom);
      end else set_arith($urandom, 5'($urandom), 1'($urandom));
      step(1);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
